gray_counter_n: RTL and testbench
=================================

// Module: gray_counter_n
// PURPOSE
//  Parametrised up/down Gray-code counter. Successor to the fixed 3-bit up-only Gray counter.
//  Adds runtime direction, synchronous load, a binary shadow output and selectable overflow mode.
//  Used as a Gray pointer source for clock-domain-crossing FIFO pointers and glitch-free step encoders.
//  Single clock domain. Output is registered, so it is safe to sample from another domain.
// PARAMETERS
//  WIDTH      3  counter width in bits; legal range 2..16; period is 2**WIDTH
//  OVF_STICKY 1  1: Overflow holds until Clr_ovf or Reset; 0: Overflow is a one-cycle pulse
// PORTS
//  Clk       in   1      rising-edge clock
//  Reset     in   1      asynchronous, active-low reset (asserts immediately, releases on Clk edge)
//  En        in   1      count enable; one step per cycle while high
//  Up        in   1      direction: 1 = up (binary +1), 0 = down (binary -1); sampled only when En=1
//  Load      in   1      synchronous load of Load_val; overrides En
//  Load_val  in   WIDTH  value to load, Gray-coded
//  Clr_ovf   in   1      clears sticky Overflow (ignored when OVF_STICKY=0)
//  Output    out  WIDTH  current count, Gray code, registered
//  Bin_out   out  WIDTH  current count, binary, registered; always gray2bin(Output)
//  Overflow  out  1      wrap indication, per OVF_STICKY
//  Wrap      out  1      one-cycle pulse in the cycle after any wrap, in both modes
// BEHAVIOUR
//  State: binary register B[WIDTH-1:0]. Output = B ^ (B>>1), registered with B.
//  Reset asserted (Reset=0): B=0, Output=0, Bin_out=0, Overflow=0, Wrap=0, asynchronously.
//   Mid-count reset aborts the count. No pending wrap or overflow survives reset.
//  Priority per rising edge: Load > En > hold.
//   Load=1: B <= gray2bin(Load_val).
//    No wrap is flagged on a load. Wrap=0 that cycle.
//    Overflow is unchanged apart from the Clr_ovf rule.
//   En=1, Up=1: B <= B+1 (mod 2**WIDTH).
//    The wrap event is B == 2**WIDTH-1 -> 0.
//   En=1, Up=0: B <= B-1 (mod 2**WIDTH).
//    The wrap event is B == 0 -> 2**WIDTH-1.
//   En=0, Load=0: B holds. Wrap=0.
//  Gray property: consecutive Output values differ in exactly one bit. This holds across wrap in both directions.
//  Latency: Output and Bin_out reflect a step or load on the edge where it is sampled, i.e. one cycle.
//  Wrap <= wrap event. Registered, one cycle wide.
//  Overflow, OVF_STICKY=1:
//   wrap event -> 1.
//   Clr_ovf=1 and no wrap event -> 0.
//   Clr_ovf=1 and wrap event in the same cycle -> 1 (set wins).
//   Otherwise holds.
//  Overflow, OVF_STICKY=0: Overflow == Wrap. Clr_ovf is ignored.
//  Changing Up while En=1 takes effect on the next edge. No dead cycle. No wrap is flagged by the direction change itself.
//  Load with En=1: the load wins. The count does not step that cycle.
//  Back-to-back wraps (e.g. an up wrap, then a down wrap) each produce their own Wrap pulse.
// STRUCTURE
//  Package gray_pkg holds:
//   OVF_STICKY_MODE = 1, OVF_PULSE_MODE = 0;
//   function bin2gray(WIDTH); function gray2bin(WIDTH) (prefix XOR from the MSB).
//  Sub-module gray2bin_comb (WIDTH): purely combinational Load_val decode. Reusable by FIFO pointer synchronisers.
//  Top module: B register, next-state mux, Output/Bin_out registers, overflow/wrap logic.
// TESTING
//  Default WIDTH=3, OVF_STICKY=1 unless stated.
//  1. Release reset, En=1 Up=1 for 8 cycles.
//     -> Output 000,001,011,010,110,111,101,100,000.
//     -> Wrap pulses once on the 000 return. Overflow goes to 1 and stays at 1.
//  2. From Output=000 with Overflow=0, En=1 Up=0 for 1 cycle.
//     -> Output=100, Bin_out=111, Wrap=1, Overflow=1.
//     Then Clr_ovf=1 for 1 cycle -> Overflow=0.
//  3. Load=1 Load_val=110 with En=1 in the same cycle.
//     -> Output=110, Bin_out=100, Wrap=0.
//     Next cycle En=1 Up=1 -> 111.
//  4. Output=100 (Bin_out=111), En=1 Up=1, Clr_ovf=1 in the same cycle.
//     -> Output=000, Overflow=1 (set wins).
//  5. OVF_STICKY=0, WIDTH=4: count up 16 cycles.
//     -> Overflow high for exactly 1 cycle.
//     -> Every step changes exactly 1 bit of Output.
//  6. Drive Reset=0 asynchronously mid-cycle at Output=011.
//     -> All outputs 0 before the next Clk edge.
//     -> The first step after release gives 001.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants and Gray/binary conversion helpers for the Gray counter family.
package gray_pkg;

  // Widest counter supported; helpers work on this width and callers truncate.
  localparam int MAX_W = 16;

  // Overflow behaviour selectors.
  localparam int OVF_STICKY_MODE = 1;
  localparam int OVF_PULSE_MODE  = 0;

  // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1'b1);
  endfunction

  // Gray to binary: prefix XOR running down from the MSB. Zero-extended
  // upper bits leave the result unchanged, so narrower values decode correctly.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Purely combinational Gray-to-binary decoder, reusable by pointer synchronisers.
module gray2bin_comb
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Decode through the shared helper and keep the low WIDTH bits.
  always_comb begin
    bin_o = WIDTH'(gray2bin(MAX_W'(gray_i)));
  end

endmodule

// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray-code counter with synchronous load, binary shadow
// output, a one-cycle wrap pulse and a sticky or pulsed overflow flag.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int OVF_STICKY = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_val,
  input  logic             Clr_ovf,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Bin_out,
  output logic             Overflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] BIN_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] BIN_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] BIN_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] load_bin_s;

  gray2bin_comb #(
    .WIDTH (WIDTH)
  ) u_load_dec (
    .gray_i (Load_val),
    .bin_o  (load_bin_s)
  );

  // Next binary count: load beats a step, a step beats hold; flag wrap events.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (Load) begin
      bin_d  = load_bin_s;
      wrap_d = 1'b0;
    end else if (En) begin
      if (Up) begin
        bin_d  = bin_q + BIN_ONE;
        wrap_d = (bin_q == BIN_MAX);
      end else begin
        bin_d  = bin_q - BIN_ONE;
        wrap_d = (bin_q == BIN_ZERO);
      end
    end else begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
    end
  end

  // Gray image of the next count, registered alongside the binary value.
  always_comb begin
    gray_d = WIDTH'(bin2gray(MAX_W'(bin_d)));
  end

  // Overflow: sticky with set-over-clear, or a copy of the wrap event.
  always_comb begin
    ovf_d = ovf_q;
    if (OVF_STICKY == OVF_STICKY_MODE) begin
      if (wrap_d) begin
        ovf_d = 1'b1;
      end else if (Clr_ovf) begin
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      ovf_d = wrap_d;
    end
  end

  // State and output registers; reset clears everything including pending flags.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bin_q  <= BIN_ZERO;
      gray_q <= BIN_ZERO;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Output   = gray_q;
  assign Bin_out  = bin_q;
  assign Overflow = ovf_q;
  assign Wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n: a 3-bit sticky instance and a 4-bit
// pulse-mode instance, driven by directed sequences and random stimulus.
module tb_gray_counter_n;

  typedef struct {
    int g;
    int b;
    bit ovf;
    bit wrap;
    bit stepped;
    int prev_g;
  } exp_t;

  logic       Clk;
  logic       Reset;
  // 3-bit sticky instance
  logic       en3, up3, load3, clr3;
  logic [2:0] lval3;
  logic [2:0] out3, bin3;
  logic       ovf3_o, wrap3_o;
  // 4-bit pulse instance
  logic       en4, up4, load4, clr4;
  logic [3:0] lval4;
  logic [3:0] out4, bin4;
  logic       ovf4_o, wrap4_o;

  int   checks = 0;
  int   errors = 0;
  exp_t q3[$];
  exp_t q4[$];
  int   cnt3 = 0, cnt4 = 0;
  bit   ovf3 = 1'b0, ovf4 = 1'b0;
  bit   count_ovf4 = 1'b0;
  int   ovf4_pulses = 0;

  gray_counter_n #(.WIDTH(3), .OVF_STICKY(1)) dut3 (
    .Clk(Clk), .Reset(Reset), .En(en3), .Up(up3), .Load(load3),
    .Load_val(lval3), .Clr_ovf(clr3), .Output(out3), .Bin_out(bin3),
    .Overflow(ovf3_o), .Wrap(wrap3_o)
  );

  gray_counter_n #(.WIDTH(4), .OVF_STICKY(0)) dut4 (
    .Clk(Clk), .Reset(Reset), .En(en4), .Up(up4), .Load(load4),
    .Load_val(lval4), .Clr_ovf(clr4), .Output(out4), .Bin_out(bin4),
    .Overflow(ovf4_o), .Wrap(wrap4_o)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int to_gray(input int v);
    return v ^ (v >> 1);
  endfunction

  // Decode by search: the value whose Gray image matches.
  function automatic int from_gray(input int g, input int per);
    for (int v = 0; v < per; v++) begin
      if (to_gray(v) == g) return v;
    end
    return -1;
  endfunction

  // Reference behaviour of one clock edge, in plain modular arithmetic.
  task automatic model(input int per, input bit sticky, inout int cnt, inout bit ovf,
                       input bit en, input bit up, input bit load, input int lval,
                       input bit clr, output exp_t e);
    bit wrap;
    e.prev_g  = to_gray(cnt);
    e.stepped = en && !load;
    wrap = 1'b0;
    if (load) begin
      cnt = from_gray(lval, per);
    end else if (en) begin
      if (up) begin
        wrap = (cnt == per - 1);
        cnt  = (cnt + 1) % per;
      end else begin
        wrap = (cnt == 0);
        cnt  = (cnt + per - 1) % per;
      end
    end
    if (sticky) begin
      if (wrap) ovf = 1'b1;
      else if (clr) ovf = 1'b0;
    end else begin
      ovf = wrap;
    end
    e.g = to_gray(cnt);
    e.b = cnt;
    e.ovf = ovf;
    e.wrap = wrap;
  endtask

  task automatic step3(input bit en, input bit up, input bit load, input int lval, input bit clr);
    exp_t e;
    @(negedge Clk);
    en3 = en; up3 = up; load3 = load; lval3 = 3'(lval); clr3 = clr;
    model(8, 1'b1, cnt3, ovf3, en, up, load, lval, clr, e);
    q3.push_back(e);
  endtask

  task automatic step4(input bit en, input bit up, input bit load, input int lval, input bit clr);
    exp_t e;
    @(negedge Clk);
    en4 = en; up4 = up; load4 = load; lval4 = 4'(lval); clr4 = clr;
    model(16, 1'b0, cnt4, ovf4, en, up, load, lval, clr, e);
    q4.push_back(e);
  endtask

  task automatic check_outputs(input string name, input exp_t e, input int g, input int b,
                               input bit ovf, input bit wrap);
    checks++;
    if (g != e.g || b != e.b || ovf != e.ovf || wrap != e.wrap) begin
      errors++;
      $display("FAIL %s: got gray=%0h bin=%0h ovf=%0b wrap=%0b, want gray=%0h bin=%0h ovf=%0b wrap=%0b",
               name, g, b, ovf, wrap, e.g, e.b, e.ovf, e.wrap);
    end
    if (e.stepped) begin
      checks++;
      if ($countones(g ^ e.prev_g) != 1) begin
        errors++;
        $display("FAIL %s_onebit: got gray=%0h after %0h, want exactly one bit changed",
                 name, g, e.prev_g);
      end
    end
  endtask

  // Monitor: compare each presented output against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q3.size() > 0) begin
        e = q3.pop_front();
        check_outputs("dut3", e, int'(out3), int'(bin3), ovf3_o, wrap3_o);
      end
      if (q4.size() > 0) begin
        e = q4.pop_front();
        check_outputs("dut4", e, int'(out4), int'(bin4), ovf4_o, wrap4_o);
      end
      if (count_ovf4 && ovf4_o) ovf4_pulses++;
    end
  end

  // Asynchronous reset mid-cycle; outputs must clear before the next edge.
  task automatic async_reset(input string name);
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (out3 != 3'd0 || bin3 != 3'd0 || ovf3_o || wrap3_o ||
        out4 != 4'd0 || bin4 != 4'd0 || ovf4_o || wrap4_o) begin
      errors++;
      $display("FAIL %s: got out3=%0h bin3=%0h ovf3=%0b wrap3=%0b out4=%0h bin4=%0h ovf4=%0b wrap4=%0b, want all zero",
               name, out3, bin3, ovf3_o, wrap3_o, out4, bin4, ovf4_o, wrap4_o);
    end
    cnt3 = 0; ovf3 = 1'b0; cnt4 = 0; ovf4 = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic drain;
    int budget;
    budget = 20;
    while ((q3.size() > 0 || q4.size() > 0) && budget > 0) begin
      @(posedge Clk);
      budget--;
    end
    #2;
    checks++;
    if (q3.size() > 0 || q4.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expectations, want 0", q3.size(), q4.size());
    end
  endtask

  initial begin
    Reset = 1'b0;
    en3 = 1'b0; up3 = 1'b0; load3 = 1'b0; clr3 = 1'b0; lval3 = 3'd0;
    en4 = 1'b0; up4 = 1'b0; load4 = 1'b0; clr4 = 1'b0; lval4 = 4'd0;
    #3;
    checks++;
    if (out3 != 3'd0 || bin3 != 3'd0 || ovf3_o || wrap3_o || out4 != 4'd0 || ovf4_o) begin
      errors++;
      $display("FAIL reset_state: got out3=%0h bin3=%0h ovf3=%0b wrap3=%0b out4=%0h ovf4=%0b, want all zero",
               out3, bin3, ovf3_o, wrap3_o, out4, ovf4_o);
    end
    @(negedge Clk);
    Reset = 1'b1;

    // Full up cycle with wrap back to 000; overflow sticks.
    for (int i = 0; i < 8; i++) step3(1'b1, 1'b1, 1'b0, 0, 1'b0);
    step3(1'b0, 1'b0, 1'b0, 0, 1'b0);
    // Clear overflow, then step down from 000 and clear again.
    step3(1'b0, 1'b0, 1'b0, 0, 1'b1);
    step3(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step3(1'b0, 1'b0, 1'b0, 0, 1'b1);
    // Load beats enable, then count on.
    step3(1'b1, 1'b1, 1'b1, 6, 1'b0);
    step3(1'b1, 1'b1, 1'b0, 0, 1'b0);
    // Wrap and clear in the same cycle: set wins.
    step3(1'b0, 1'b0, 1'b1, 4, 1'b0);
    step3(1'b1, 1'b1, 1'b0, 0, 1'b1);
    // Back-to-back wraps: down from 000, then up from 111.
    step3(1'b1, 1'b0, 1'b0, 0, 1'b1);
    step3(1'b1, 1'b1, 1'b0, 0, 1'b0);
    // Direction change mid-count without a dead cycle.
    step3(1'b1, 1'b1, 1'b0, 0, 1'b0);
    step3(1'b1, 1'b0, 1'b0, 0, 1'b0);
    // Count to 011, then reset asynchronously.
    step3(1'b0, 1'b0, 1'b1, 0, 1'b1);
    step3(1'b1, 1'b1, 1'b0, 0, 1'b0);
    step3(1'b1, 1'b1, 1'b0, 0, 1'b0);
    step3(1'b0, 1'b0, 1'b0, 0, 1'b0);
    drain();
    async_reset("async_reset_mid_count");
    step3(1'b1, 1'b1, 1'b0, 0, 1'b0);
    step3(1'b0, 1'b0, 1'b0, 0, 1'b0);
    drain();

    // Pulse-mode 4-bit instance: 16 up steps give exactly one overflow cycle.
    count_ovf4 = 1'b1;
    for (int i = 0; i < 16; i++) step4(1'b1, 1'b1, 1'b0, 0, 1'b1);
    step4(1'b0, 1'b0, 1'b0, 0, 1'b0);
    drain();
    count_ovf4 = 1'b0;
    checks++;
    if (ovf4_pulses != 1) begin
      errors++;
      $display("FAIL ovf_pulse_count: got %0d overflow cycles, want 1", ovf4_pulses);
    end

    // Random stimulus on both instances.
    for (int i = 0; i < 200; i++) begin
      step3($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, $urandom_range(7, 0) == 0,
            int'($urandom_range(7, 0)), $urandom_range(3, 0) == 0);
    end
    step3(1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      step4($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, $urandom_range(7, 0) == 0,
            int'($urandom_range(15, 0)), $urandom_range(3, 0) == 0);
    end
    step4(1'b0, 1'b0, 1'b0, 0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
